// File: rtl/parity_frame_arbiter.sv
// parity_frame_arbiter: round-robin arbiter that shares one nibble parity datapath among
// NUM_REQ requesters and returns one tagged parity result per frame.
// Optional feature: define PARITY_ODD_EN to report odd parity (inverted XOR) instead of even.
module parity_frame_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [4*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_parity,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [7:0]                 res_len,
  output logic                       res_overflow
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

`ifdef PARITY_ODD_EN
  localparam logic PAR_INV = 1'b1;
`else
  localparam logic PAR_INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StResult
  } state_e;

  state_e            state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   ptr;
  logic              acc;
  logic [7:0]        cnt;
  logic              ovf;
  logic              res_valid_q;

  logic              arb_found;
  logic [ID_W-1:0]   arb_sel;
  int                arb_idx;
  logic              beat;
  logic [3:0]        beat_nib;

  // Round-robin search starting just after the last-served requester.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = (int'(ptr) + k) % NUM_REQ;
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found = 1'b1;
        arb_sel   = ID_W'(arb_idx);
      end
    end
  end

  // Ready is decoded from state and registered grant only, never from req_valid.
  always_comb begin
    req_ready = '0;
    if (state == StStream) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Beat qualification and the granted requester's nibble.
  always_comb begin
    beat     = (state == StStream) && req_valid[grant];
    beat_nib = req_data[{grant, 2'b00} +: 4];
  end

  // Frame FSM with accumulator, saturating length counter and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      grant       <= '0;
      ptr         <= ID_W'(NUM_REQ - 1);
      acc         <= 1'b0;
      cnt         <= '0;
      ovf         <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (arb_found) begin
            grant <= arb_sel;
            acc   <= 1'b0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= StStream;
          end
        end
        StStream: begin
          if (beat) begin
            acc <= acc ^ (^beat_nib);
            if (cnt == MAX_CNT) begin
              ovf <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
            if (req_last[grant]) begin
              state       <= StResult;
              res_valid_q <= 1'b1;
            end
          end
        end
        StResult: begin
          if (res_ready) begin
            ptr         <= grant;
            res_valid_q <= 1'b0;
            state       <= StIdle;
          end
        end
        default: begin
          state       <= StIdle;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result fields come straight from registered state; parity is gated so the odd build
  // still reads 0 out of reset.
  always_comb begin
    res_valid    = res_valid_q;
    res_parity   = res_valid_q & (acc ^ PAR_INV);
    res_id       = grant;
    res_len      = cnt;
    res_overflow = ovf;
  end

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// Testbench for parity_frame_arbiter: table-driven frames plus directed sequences for
// round-robin order, result backpressure and asynchronous reset mid-frame.
module tb_parity_frame_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MAX_LEN = 4;

`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_parity;
  logic [1:0]           res_id;
  logic [7:0]           res_len;
  logic                 res_overflow;

  int tests;
  int fails;

  parity_frame_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_parity  (res_parity),
    .res_id      (res_id),
    .res_len     (res_len),
    .res_overflow(res_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          n;
    logic [31:0] data;  // nibble k at bits [4k+3:4k]
    logic        par;   // even parity
    int          len;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Streams a frame from one requester; returns at the negedge just after the last beat.
  task automatic send_frame(input int id, input int n, input logic [31:0] data);
    int t;
    req_valid = '0;
    req_last  = '0;
    for (int k = 0; k < n; k++) begin
      req_valid[id]        = 1'b1;
      req_data[id*4 +: 4]  = data[k*4 +: 4];
      req_last[id]         = (k == n - 1);
      t = 0;
      while (!req_ready[id] && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
      if (k == n - 1) check("res_valid_early", 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int last_cyc;
    int cyc;

    tests = 0;
    fails = 0;

    vecs[0] = '{id: 2, n: 3, data: 32'h0000_061B, par: 1'b0, len: 3, ovf: 1'b0};
    vecs[1] = '{id: 1, n: 6, data: 32'h0011_1111, par: 1'b0, len: 4, ovf: 1'b1};
    vecs[2] = '{id: 0, n: 1, data: 32'h0000_0007, par: 1'b1, len: 1, ovf: 1'b0};
    vecs[3] = '{id: 3, n: 4, data: 32'h0000_031F, par: 1'b1, len: 4, ovf: 1'b0};
    vecs[4] = '{id: 1, n: 5, data: 32'h000F_8421, par: 1'b0, len: 4, ovf: 1'b1};
    vecs[5] = '{id: 2, n: 2, data: 32'h0000_0000, par: 1'b0, len: 2, ovf: 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    res_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_fields", {26'd0, res_valid, res_parity, res_id, res_overflow, 1'b0},
          32'd0);
    check("rst_res_len", 32'(res_len), 32'd0);

    // Round-robin: all requesters continuously offer 1-nibble frames of 0001
    rst       = 1'b0;
    req_valid = 4'hF;
    req_data  = 16'h1111;
    req_last  = 4'hF;
    got       = 0;
    last_cyc  = 0;
    cyc       = 0;
    while (got < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        check("rr_id", 32'(res_id), 32'(got % 4));
        check("rr_parity", 32'(res_parity), 32'(1'b1 ^ ODD));
        check("rr_len", 32'(res_len), 32'd1);
        if (got > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        got++;
      end
    end
    if (got < 5) check("rr_timeout", 32'(got), 32'd5);
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].id, vecs[v].n, vecs[v].data);
      check("tbl_res_valid", 32'(res_valid), 32'd1);
      check("tbl_parity", 32'(res_parity), 32'(vecs[v].par ^ ODD));
      check("tbl_id", 32'(res_id), 32'(vecs[v].id));
      check("tbl_len", 32'(res_len), 32'(vecs[v].len));
      check("tbl_ovf", 32'(res_overflow), 32'(vecs[v].ovf));
      @(negedge clk);
      check("tbl_res_drop", 32'(res_valid), 32'd0);
    end

    // Backpressure: result held for 5 cycles while requester 1 waits
    res_ready = 1'b0;
    send_frame(0, 1, 32'h0000_0005);
    req_valid[1]    = 1'b1;
    req_data[7:4]   = 4'h1;
    req_last[1]     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_hold", {19'd0, res_valid, req_ready, res_id, res_len[3:0], res_overflow,
                        res_parity},
            {19'd0, 1'b1, 4'b0000, 2'd0, 4'd1, 1'b0, 1'b0 ^ ODD});
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'd0);
    check("bp_idle_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    req_last  = '0;
    check("bp_next_id", 32'(res_id), 32'd1);
    check("bp_next_parity", 32'(res_parity), 32'(1'b1 ^ ODD));
    @(negedge clk);

    // Reset mid-frame from requester 3
    req_valid[3]     = 1'b1;
    req_data[15:12]  = 4'h1;
    req_last[3]      = 1'b0;
    cyc = 0;
    while (!req_ready[3] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) check("mid_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("mid_len_before", 32'(res_len), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_len", 32'(res_len), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1001;
    req_data  = 16'h1001;
    req_last  = 4'b1001;
    @(negedge clk);
    check("post_rst_grant0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check("post_rst_res0", {30'd0, res_valid, 1'b0} | 32'(res_id), 32'b10);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_grant3", 32'(req_ready), 32'b1000);
    req_valid = '0;
    @(negedge clk);
    check("post_rst_valid3", 32'(res_valid), 32'd0);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    req_last  = '0;
    check("post_rst_res3_id", 32'(res_id), 32'd3);
    check("post_rst_res3_len", 32'(res_len), 32'd1);
    check("post_rst_res3_valid", 32'(res_valid), 32'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
